multi_tick_generator: RTL

//  Multi-channel successor to the single fixed-rate tick generator: NrOfChannels independent

---
 rtl/tick_gen_pkg.sv | 38 +++
 rtl/tick_channel.sv | 68 ++++++
 rtl/multi_tick_generator.sv | 81 ++++++++
 3 files changed

// File: rtl/tick_gen_pkg.sv
// -----------------------------------------------------------------------------
// tick_gen_pkg
//   Shared helpers for the multi-channel tick generator.
//   - clog2 / cfg_width : width of the configuration channel selector
//   - MaxChannels       : upper bound on the number of tick channels
//   - chan_idx_t        : channel index wide enough for MaxChannels
// -----------------------------------------------------------------------------
package tick_gen_pkg;

    localparam int MaxChannels = 32;

    // Ceiling log2. clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Channel selector width. Never narrower than one bit, so a single-channel
    // build still has a usable CfgChannel port.
    function automatic int cfg_width(input int nr_of_channels);
        int w;
        w = clog2(nr_of_channels);
        return (w < 1) ? 1 : w;
    endfunction

    // Wide enough to index any legal channel. Writes are decoded in this
    // width so that selector values beyond the built channel count match
    // no channel and are silently dropped.
    typedef logic [clog2(MaxChannels)-1:0] chan_idx_t;

endpackage

// File: rtl/tick_channel.sv
// -----------------------------------------------------------------------------
// tick_channel
//   One tick channel: a down-counter, its reload register and the registered
//   tick pulse.
//   Ports:
//     clk      in   clock, all state on rising edge
//     rst_n    in   asynchronous active-low reset
//     adv      in   advance the counter this cycle
//     restart  in   synchronous restart to phase 0 (overrides adv)
//     wr_en    in   load wr_data into the reload register
//     wr_data  in   new reload value R
//     tick     out  one-cycle pulse, high the cycle after an advance at count 0
// -----------------------------------------------------------------------------
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int NrOfBits    = 16,
    parameter int ReloadValue = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                adv,
    input  logic                restart,
    input  logic                wr_en,
    input  logic [NrOfBits-1:0] wr_data,
    output logic                tick
);

    localparam logic [NrOfBits-1:0] CountOne = NrOfBits'(1);

    logic [NrOfBits-1:0] count_reg;
    logic [NrOfBits-1:0] reload_reg;
    logic                tick_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= '0;
            reload_reg <= NrOfBits'(ReloadValue);
            tick_reg   <= 1'b0;
        end else begin
            // The reload register updates independently of the counter. A
            // write landing on the same edge as a reload is not seen by that
            // reload, which still uses the previous value of reload_reg.
            if (wr_en) begin
                reload_reg <= wr_data;
            end

            if (restart) begin
                count_reg <= '0;
                tick_reg  <= 1'b0;
            end else if (adv) begin
                if (count_reg == '0) begin
                    // R = 0 wraps to all-ones, giving a 2^NrOfBits period.
                    count_reg <= reload_reg - CountOne;
                    tick_reg  <= 1'b1;
                end else begin
                    count_reg <= count_reg - CountOne;
                    tick_reg  <= 1'b0;
                end
            end else begin
                tick_reg <= 1'b0;
            end
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/multi_tick_generator.sv
// -----------------------------------------------------------------------------
// multi_tick_generator
//   NrOfChannels independent tick channels, each pulsing FPGATick[i] for one
//   clock every R[i] advances. R is reprogrammable per channel at run time.
//   Ports:
//     FPGAClock      in   single clock
//     FPGAReset_n    in   asynchronous active-low reset
//     CfgWrite       in   reload-register write strobe
//     CfgChannel     in   channel addressed by CfgWrite (out-of-range ignored)
//     CfgReload      in   new reload value R (0 means 2^NrOfBits)
//     ChannelEnable  in   per-channel advance enable
//     SyncRestart    in   return every counter to phase 0
//     CascadeMask    in   only with TICK_CASCADE_EN: channel i>0 also needs
//                         the previous channel's tick to advance
//     FPGATick       out  registered one-cycle tick pulses
//   Optional feature macro: TICK_CASCADE_EN (cascade chaining of channels).
// -----------------------------------------------------------------------------
module multi_tick_generator
    import tick_gen_pkg::*;
#(
    parameter int NrOfBits     = 16,
    parameter int NrOfChannels = 4,
    parameter int ReloadValue  = 1
) (
    input  logic                                FPGAClock,
    input  logic                                FPGAReset_n,
    input  logic                                CfgWrite,
    input  logic [cfg_width(NrOfChannels)-1:0]  CfgChannel,
    input  logic [NrOfBits-1:0]                 CfgReload,
    input  logic [NrOfChannels-1:0]             ChannelEnable,
    input  logic                                SyncRestart,
`ifdef TICK_CASCADE_EN
    input  logic [NrOfChannels-1:0]             CascadeMask,
`endif
    output logic [NrOfChannels-1:0]             FPGATick
);

    logic [NrOfChannels-1:0] adv;
    logic [NrOfChannels-1:0] wr_sel;

`ifdef TICK_CASCADE_EN
    // Channel 0 has no predecessor, so its mask bit has no effect.
    logic cascade_unused;
    assign cascade_unused = CascadeMask[0];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NrOfChannels; gi = gi + 1) begin : g_channel
            // Decode in the full index width so selector values at or above
            // NrOfChannels address nothing.
            assign wr_sel[gi] = CfgWrite && (chan_idx_t'(CfgChannel) == chan_idx_t'(gi));

            if (gi == 0) begin : g_first
                assign adv[gi] = ChannelEnable[gi];
            end else begin : g_rest
`ifdef TICK_CASCADE_EN
                // Cascaded channels count the previous channel's registered
                // ticks, so the chain period is the product of the R values.
                assign adv[gi] = ChannelEnable[gi] & (~CascadeMask[gi] | FPGATick[gi-1]);
`else
                assign adv[gi] = ChannelEnable[gi];
`endif
            end

            tick_channel #(
                .NrOfBits    (NrOfBits),
                .ReloadValue (ReloadValue)
            ) u_channel (
                .clk     (FPGAClock),
                .rst_n   (FPGAReset_n),
                .adv     (adv[gi]),
                .restart (SyncRestart),
                .wr_en   (wr_sel[gi]),
                .wr_data (CfgReload),
                .tick    (FPGATick[gi])
            );
        end
    endgenerate

endmodule
